// File: rtl/mem_stage_ld.sv
// Memory-access pipeline stage: latches the execute bundle, extracts load data from the
// synchronous data SRAM (or a one-entry hold buffer while writeback stalls) and forwards results.
module mem_stage_ld #(
    parameter int EX_TO_MEM_W = 110,
    parameter int MEM_TO_WB_W = 70
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ex_to_mem_valid,
    input  logic [EX_TO_MEM_W-1:0] ex_to_mem_wire,
    output logic                   mem_allowin,
    input  logic                   wb_allowin,
    output logic                   mem_to_wb_valid,
    output logic [MEM_TO_WB_W-1:0] mem_to_wb_wire,
    output logic [38:0]            mem_rf_zip,
    input  logic [31:0]            data_sram_rdata
);

    logic                   mem_valid_r;
    logic                   first_cyc_r;
    logic                   rdata_held_r;
    logic [31:0]            hold_r;
    logic [EX_TO_MEM_W-1:0] bundle_r;

    logic                   capture_s;
    logic [2:0]             ld_op_s;
    logic                   rf_we_s;
    logic [4:0]             rf_waddr_s;
    logic [31:0]            pc_s;
    logic [31:0]            alu_result_s;
    logic                   res_from_mem_s;
    logic [31:0]            src_word_s;
    logic [7:0]             byte_s;
    logic [15:0]            half_s;
    logic [31:0]            extracted_s;
    logic [31:0]            final_result_s;

    assign mem_allowin     = ~mem_valid_r | wb_allowin;
    assign mem_to_wb_valid = mem_valid_r;
    assign capture_s       = ex_to_mem_valid & mem_allowin;

    assign ld_op_s        = bundle_r[109:107];
    assign rf_we_s        = bundle_r[106];
    assign rf_waddr_s     = bundle_r[105:101];
    assign pc_s           = bundle_r[100:69];
    assign alu_result_s   = bundle_r[68:37];
    assign res_from_mem_s = bundle_r[4];

    // Valid bit and first-cycle marker: SRAM data is only live right after a capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_r <= 1'b0;
            first_cyc_r <= 1'b0;
        end else begin
            if (mem_allowin) begin
                mem_valid_r <= ex_to_mem_valid;
            end else begin
                mem_valid_r <= mem_valid_r;
            end
            first_cyc_r <= capture_s;
        end
    end

    // Bundle register loads only on an accepted handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bundle_r <= {EX_TO_MEM_W{1'b0}};
        end else if (capture_s) begin
            bundle_r <= ex_to_mem_wire;
        end else begin
            bundle_r <= bundle_r;
        end
    end

    // Hold buffer: whenever the stage accepts (capture or drain) the held word is stale.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r       <= 32'h0000_0000;
            rdata_held_r <= 1'b0;
        end else if (mem_allowin) begin
            hold_r       <= hold_r;
            rdata_held_r <= 1'b0;
        end else if (first_cyc_r && mem_valid_r) begin
            hold_r       <= data_sram_rdata;
            rdata_held_r <= 1'b1;
        end else begin
            hold_r       <= hold_r;
            rdata_held_r <= rdata_held_r;
        end
    end

    assign src_word_s = rdata_held_r ? hold_r : data_sram_rdata;

    // Byte and half-word lane select; misaligned addresses just use the low bits.
    always_comb begin
        byte_s = 8'h00;
        case (alu_result_s[1:0])
            2'd0:    byte_s = src_word_s[7:0];
            2'd1:    byte_s = src_word_s[15:8];
            2'd2:    byte_s = src_word_s[23:16];
            2'd3:    byte_s = src_word_s[31:24];
            default: byte_s = src_word_s[7:0];
        endcase
        if (alu_result_s[1]) begin
            half_s = src_word_s[31:16];
        end else begin
            half_s = src_word_s[15:0];
        end
    end

    // Sign/zero extension by load type; unused encodings behave as a word load.
    always_comb begin
        extracted_s = src_word_s;
        case (ld_op_s)
            3'd1:    extracted_s = {{24{byte_s[7]}}, byte_s};
            3'd2:    extracted_s = {{16{half_s[15]}}, half_s};
            3'd3:    extracted_s = {24'h00_0000, byte_s};
            3'd4:    extracted_s = {16'h0000, half_s};
            default: extracted_s = src_word_s;
        endcase
    end

    assign final_result_s = res_from_mem_s ? extracted_s : alu_result_s;

    assign mem_to_wb_wire = {rf_we_s, rf_waddr_s, pc_s, final_result_s};
    assign mem_rf_zip     = {res_from_mem_s & mem_valid_r, rf_we_s & mem_valid_r,
                             rf_waddr_s, final_result_s};

endmodule

// File: tb/tb_mem_stage_ld.sv
// Randomized and directed bench for mem_stage_ld against a transaction-level reference model.
module tb_mem_stage_ld;

    logic         clk;
    logic         resetn;
    logic         ex_to_mem_valid;
    logic [109:0] ex_to_mem_wire;
    logic         mem_allowin;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [69:0]  mem_to_wb_wire;
    logic [38:0]  mem_rf_zip;
    logic [31:0]  data_sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the instruction currently in MEM and the word the SRAM returned for it.
    logic         m_valid = 1'b0;
    logic         m_first = 1'b0;
    logic [109:0] m_bundle = '0;
    logic [31:0]  m_word = 32'h0;

    mem_stage_ld dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_wire  (ex_to_mem_wire),
        .mem_allowin     (mem_allowin),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_wire  (mem_to_wb_wire),
        .mem_rf_zip      (mem_rf_zip),
        .data_sram_rdata (data_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [109:0] mk(input logic [2:0] op, input logic we, input logic [4:0] wa,
                                        input logic [31:0] pc, input logic [31:0] alu,
                                        input logic rfm, input logic [3:0] mwe);
        logic [31:0] rkd;
        rkd = $urandom;
        return {op, we, wa, pc, alu, rkd, rfm, mwe};
    endfunction

    // Load result from plain arithmetic on the returned word.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint v;
        int     bsh;
        int     hsh;
        bsh = 8 * int'(addr % 4);
        hsh = 16 * int'((addr / 2) % 2);
        case (op)
            3'd1: begin v = (longint'(word) >> bsh) % 256;   if (v > 127)   v = v - 256;   end
            3'd2: begin v = (longint'(word) >> hsh) % 65536; if (v > 32767) v = v - 65536; end
            3'd3: v = (longint'(word) >> bsh) % 256;
            3'd4: v = (longint'(word) >> hsh) % 65536;
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_final();
        logic [31:0] alu;
        alu = m_bundle[68:37];
        return m_bundle[4] ? ref_load(m_bundle[109:107], alu, m_word) : alu;
    endfunction

    // One clock cycle: entered at posedge+1, drives inputs, checks at negedge, advances the model.
    task automatic step(input logic ev, input logic [109:0] w, input logic wba,
                        input logic [31:0] ld_word, input logic dchk, input logic [31:0] dval);
        logic [31:0] fr;
        logic [31:0] junk;
        ex_to_mem_valid = ev;
        ex_to_mem_wire  = w;
        wb_allowin      = wba;
        junk            = $urandom;
        data_sram_rdata = m_first ? m_word : junk;
        #4;
        fr = ref_final();
        check_eq("valid", {69'd0, mem_to_wb_valid}, {69'd0, m_valid});
        check_eq("allowin", {69'd0, mem_allowin}, {69'd0, (!m_valid || wba)});
        if (m_valid) begin
            check_eq("wb_wire", mem_to_wb_wire, {m_bundle[106], m_bundle[105:101], m_bundle[100:69], fr});
            check_eq("zip", {31'd0, mem_rf_zip}, {31'd0, m_bundle[4], m_bundle[106], m_bundle[105:101], fr});
        end else begin
            check_eq("zip_vbits", {68'd0, mem_rf_zip[38:37]}, 70'd0);
        end
        if (dchk) begin
            check_eq("directed", {38'd0, mem_to_wb_wire[31:0]}, {38'd0, dval});
        end
        @(posedge clk);
        if (!m_valid || wba) begin
            m_valid = ev;
            m_first = ev;
            if (ev) begin
                m_bundle = w;
                m_word   = ld_word;
            end
        end else begin
            m_first = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input logic wba);
        step(1'b0, '0, wba, 32'h0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        check_eq("rst_valid", {69'd0, mem_to_wb_valid}, 70'd0);
        check_eq("rst_zip", {68'd0, mem_rf_zip[38:37]}, 70'd0);
        check_eq("rst_allowin", {69'd0, mem_allowin}, 70'd1);
        m_valid = 1'b0;
        m_first = 1'b0;
        ex_to_mem_valid = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [109:0] w;
        logic [2:0]   op;
        int           kind;
        resetn          = 1'b0;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_wire  = '0;
        wb_allowin      = 1'b1;
        data_sram_rdata = 32'h0;
        #12;
        check_eq("init_valid", {69'd0, mem_to_wb_valid}, 70'd0);
        check_eq("init_allowin", {69'd0, mem_allowin}, 70'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ld.b at byte 3 of 0x80FF_1234
        step(1'b1, mk(3'd1, 1'b1, 5'd3, 32'h1C00_0000, 32'h0000_1003, 1'b1, 4'h0), 1'b1,
             32'h80FF_1234, 1'b0, 32'h0);
        idle(1'b1);
        // ld.hu and ld.h on the upper half of 0x8001_7FFF
        step(1'b1, mk(3'd4, 1'b1, 5'd4, 32'h1C00_0004, 32'h0000_2002, 1'b1, 4'h0), 1'b1,
             32'h8001_7FFF, 1'b0, 32'h0);
        step(1'b1, mk(3'd2, 1'b1, 5'd7, 32'h1C00_0008, 32'h0000_2002, 1'b1, 4'h0), 1'b1,
             32'h8001_7FFF, 1'b1, 32'h0000_8001);
        step(1'b0, '0, 1'b1, 32'h0, 1'b1, 32'hFFFF_8001);
        // ld.b result check happens on the cycle right after capture
        step(1'b1, mk(3'd1, 1'b1, 5'd3, 32'h1C00_000C, 32'h0000_1003, 1'b1, 4'h0), 1'b1,
             32'h80FF_1234, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FF80);

        // ld.w held across a 3-cycle writeback stall while SRAM data turns to junk
        step(1'b1, mk(3'd0, 1'b1, 5'd9, 32'h1C00_0010, 32'h0000_3000, 1'b1, 4'h0), 1'b1,
             32'hCAFE_F00D, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(3'd0, 1'b1, 5'd10, 32'h1C00_0014, 32'h0000_3004, 1'b1, 4'h0), 1'b0,
                 32'h1111_1111, 1'b1, 32'hCAFE_F00D);
        end
        idle(1'b1);
        idle(1'b1);

        // add rd=5 then ld.w rd=6 back to back
        step(1'b1, mk(3'd0, 1'b1, 5'd5, 32'h1C00_0020, 32'h0000_1234, 1'b0, 4'h0), 1'b1,
             32'h0, 1'b0, 32'h0);
        step(1'b1, mk(3'd0, 1'b1, 5'd6, 32'h1C00_0024, 32'h0000_4000, 1'b1, 4'h0), 1'b1,
             32'h5A5A_A5A5, 1'b1, 32'h0000_1234);
        step(1'b0, '0, 1'b1, 32'h0, 1'b1, 32'h5A5A_A5A5);

        // st.w passes alu_result through with rf_we low
        step(1'b1, mk(3'd0, 1'b0, 5'd0, 32'h1C00_0030, 32'h0000_8888, 1'b0, 4'hF), 1'b1,
             32'h0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 32'h0, 1'b1, 32'h0000_8888);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 2);
            op   = 3'($urandom_range(0, 7));
            case (kind)
                0:       w = mk(op, 1'b1, 5'($urandom), $urandom, $urandom, 1'b0, 4'h0);
                1:       w = mk(op, 1'b1, 5'($urandom), $urandom, $urandom, 1'b1, 4'h0);
                default: w = mk(op, 1'b0, 5'($urandom), $urandom, $urandom, 1'b0, 4'($urandom_range(1, 15)));
            endcase
            step(1'($urandom), w, ($urandom_range(0, 3) != 0), $urandom, 1'b0, 32'h0);
            if (i == 200) begin
                do_reset();
            end
        end

        // Reset while a load sits stalled: nothing is emitted after release
        step(1'b1, mk(3'd0, 1'b1, 5'd12, 32'h1C00_0040, 32'h0000_5000, 1'b1, 4'h0), 1'b1,
             32'h7777_7777, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b1);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
